// File: rtl/sort_pkg.sv
// Shared sorter definitions: default frame geometry, frame-assembly states, index-width helper.
package sort_pkg;
  localparam int SORT_WIDTH = 16;
  localparam int SORT_N     = 4;

  typedef enum logic {COLLECT, HOLD} sort_state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/comp16b.sv
// 16-bit unsigned magnitude comparator; ag is high when a is strictly greater than b.
module comp16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ag
);
  assign ag = (a > b);
endmodule

// File: rtl/sort_unpermute.sv
// Rebuilds the original input-order vector from the sorted (value, source index) beat stream.
// Define SORT_UNPERMUTE_ORDER_CHECK_EN to flag frames whose values rise between beats.
module sort_unpermute
  import sort_pkg::*;
#(
  parameter int WIDTH = SORT_WIDTH,
  parameter int N     = SORT_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [idx_w(N)-1:0]   in_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*WIDTH-1:0]    out_data,
  output logic                  out_dup,
  output logic                  out_order
);
  localparam int IDXW = idx_w(N);
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  sort_state_e state, state_nxt;
  logic [IDXW-1:0]           cnt;
  logic [N-1:0]              seen;
  logic [N-1:0][WIDTH-1:0]   slots;
  logic                      dup;
  logic                      accept, done;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign done      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && cnt == LAST) state_nxt = HOLD;
      HOLD:    if (done)                  state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // cnt is IDXW bits and N is a power of two, so the N-th beat wraps it to 0 as we enter HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      seen  <= '0;
      slots <= '0;
      dup   <= 1'b0;
    end else if (done) begin
      cnt  <= '0;
      seen <= '0;
      dup  <= 1'b0;
    end else if (accept) begin
      slots[in_idx] <= in_data;
      seen[in_idx]  <= 1'b1;
      cnt           <= cnt + 1'b1;
      if (seen[in_idx]) dup <= 1'b1;
    end
  end

  // Slots never written in this frame read as zero
  for (genvar k = 0; k < N; k++) begin : g_slot
    assign out_data[k*WIDTH +: WIDTH] = seen[k] ? slots[k] : '0;
  end

  assign out_dup = dup && out_valid;

`ifdef SORT_UNPERMUTE_ORDER_CHECK_EN
  logic [WIDTH-1:0] prev;
  logic             order;
  logic             rise;

  comp16b u_cmp (
    .a  (in_data),
    .b  (prev),
    .ag (rise)
  );

  // cnt == 0 marks the first beat of a frame, which has no predecessor to compare against
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= '0;
      order <= 1'b0;
    end else if (done) begin
      order <= 1'b0;
    end else if (accept) begin
      prev <= in_data;
      if (rise && cnt != '0) order <= 1'b1;
    end
  end

  assign out_order = order && out_valid;
`else
  assign out_order = 1'b0;
`endif
endmodule

// File: tb/tb_sort_unpermute.sv
// Directed bench for sort_unpermute: reset, reorder, backpressure, dup, order, mid-frame reset, streaming.
module tb_sort_unpermute;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_idx;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_dup;
  logic        out_order;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sort_unpermute dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_idx    (in_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dup   (out_dup),
    .out_order (out_order)
  );

  // Offer one beat from a negedge, wait (bounded) until it is taken, return on the next negedge
  task automatic put(input logic [15:0] d, input logic [1:0] i);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_idx   = i;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vecs++; errs++;
      $display("FAIL put_timeout: in_ready stuck 0 for beat %h idx %0d", d, i);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_idx = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vecs++; if (out_data !== 64'h0) begin errs++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    vecs++; if (out_dup !== 1'b0) begin errs++; $display("FAIL rst_out_dup: got %b want 0", out_dup); end
    vecs++; if (out_order !== 1'b0) begin errs++; $display("FAIL rst_out_order: got %b want 0", out_order); end
  endtask

  task automatic test_basic();
    put(16'hF000, 2'd2); put(16'h0800, 2'd0); put(16'h0400, 2'd3);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    put(16'h0001, 2'd1);
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    vecs++; if (out_data !== 64'h0400_F000_0001_0800) begin errs++; $display("FAIL basic_data: got %h want 0400f00000010800", out_data); end
    vecs++; if (out_dup !== 1'b0) begin errs++; $display("FAIL basic_dup: got %b want 0", out_dup); end
    vecs++; if (out_order !== 1'b0) begin errs++; $display("FAIL basic_order: got %b want 0", out_order); end
    ack();
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL basic_release: valid %b ready %b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    put(16'hF000, 2'd2); put(16'h0800, 2'd0); put(16'h0400, 2'd3); put(16'h0001, 2'd1);
    in_valid = 1'b1; in_data = 16'h00AA; in_idx = 2'd3;
    for (int c = 0; c < 5; c++) begin
      vecs++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errs++; $display("FAIL bp_hold c%0d: valid %b ready %b want 1 0", c, out_valid, in_ready); end
      vecs++; if (out_data !== 64'h0400_F000_0001_0800) begin errs++; $display("FAIL bp_stable c%0d: got %h want 0400f00000010800", c, out_data); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL bp_release: valid %b ready %b want 0 1", out_valid, in_ready); end
    put(16'h00AA, 2'd3); put(16'h0099, 2'd2); put(16'h0050, 2'd1);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_beat_consumed_in_hold: valid %b want 0", out_valid); end
    put(16'h0010, 2'd0);
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
    vecs++; if (out_data !== 64'h00AA_0099_0050_0010) begin errs++; $display("FAIL bp_next_data: got %h want 00aa009900500010", out_data); end
    vecs++; if (out_dup !== 1'b0) begin errs++; $display("FAIL bp_next_dup: got %b want 0", out_dup); end
    ack();
  endtask

  task automatic test_dup();
    put(16'd9, 2'd1); put(16'd8, 2'd1); put(16'd7, 2'd2); put(16'd6, 2'd3);
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL dup_valid: got %b want 1", out_valid); end
    vecs++; if (out_dup !== 1'b1) begin errs++; $display("FAIL dup_flag: got %b want 1", out_dup); end
    vecs++; if (out_data !== 64'h0006_0007_0008_0000) begin errs++; $display("FAIL dup_data: got %h want 0006000700080000", out_data); end
    ack();
  endtask

  task automatic test_order();
    logic exp_rise;
`ifdef SORT_UNPERMUTE_ORDER_CHECK_EN
    exp_rise = 1'b1;
`else
    exp_rise = 1'b0;
`endif
    put(16'd5, 2'd0); put(16'd7, 2'd1); put(16'd3, 2'd2); put(16'd3, 2'd3);
    vecs++; if (out_order !== exp_rise) begin errs++; $display("FAIL order_rise: got %b want %b", out_order, exp_rise); end
    vecs++; if (out_data !== 64'h0003_0003_0007_0005) begin errs++; $display("FAIL order_data: got %h want 0003000300070005", out_data); end
    ack();
    put(16'd7, 2'd0); put(16'd7, 2'd1); put(16'd7, 2'd2); put(16'd7, 2'd3);
    vecs++; if (out_order !== 1'b0) begin errs++; $display("FAIL order_ties: got %b want 0", out_order); end
    vecs++; if (out_dup !== 1'b0) begin errs++; $display("FAIL order_ties_dup: got %b want 0", out_dup); end
    ack();
  endtask

  task automatic test_reset_mid();
    put(16'd100, 2'd0); put(16'd90, 2'd1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL midrst_no_output c%0d: valid %b want 0", c, out_valid); end
      @(negedge clk);
    end
    put(16'd40, 2'd3); put(16'd30, 2'd1); put(16'd20, 2'd0);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL midrst_early_valid: got %b want 0", out_valid); end
    put(16'd10, 2'd2);
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL midrst_valid: got %b want 1", out_valid); end
    vecs++; if (out_data !== 64'h0028_000A_001E_0014) begin errs++; $display("FAIL midrst_data: got %h want 0028000a001e0014", out_data); end
    vecs++; if (out_dup !== 1'b0) begin errs++; $display("FAIL midrst_dup: got %b want 0", out_dup); end
    ack();
  endtask

  task automatic test_back_to_back();
    int perm [4];
    int vals [4];
    int v, j, t, last_cyc;
    logic [63:0] exp;
    last_cyc = 0;
    out_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 4; k++) perm[k] = k;
      for (int k = 3; k > 0; k--) begin
        j = int'($urandom_range(0, k));
        t = perm[k]; perm[k] = perm[j]; perm[j] = t;
      end
      v = int'($urandom_range(16'hFFFF, 16'h8000));
      exp = '0;
      for (int k = 0; k < 4; k++) begin
        vals[k] = v;
        exp[perm[k]*16 +: 16] = 16'(v);
        v = v - int'($urandom_range(0, 2000));
      end
      for (int k = 0; k < 4; k++) put(16'(vals[k]), 2'(perm[k]));
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid f%0d: got %b want 1", f, out_valid); end
      vecs++; if (out_data !== exp) begin errs++; $display("FAIL b2b_data f%0d: got %h want %h", f, out_data, exp); end
      vecs++; if (out_dup !== 1'b0 || out_order !== 1'b0) begin errs++; $display("FAIL b2b_flags f%0d: dup %b order %b want 0 0", f, out_dup, out_order); end
      if (f > 0) begin
        vecs++; if (cyc - last_cyc != 5) begin errs++; $display("FAIL b2b_period f%0d: got %0d cycles want 5", f, cyc - last_cyc); end
      end
      last_cyc = cyc;
    end
    @(negedge clk);
    out_ready = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain: valid %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_dup();
    test_order();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
